instr_fetch: RTL and testbench

Instruction fetch and prefetch stage that sits directly upstream of the control FSM. It holds the program store, a program counter and a 2-entry prefetch queue, and presents one instruction at a time to the FSM. Each instruction is {opcode, argA, argB}. The FSM pulses `done` to consume the head instruction. A `branch` request flushes the queue and redirects fetch.

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 132 +++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch/prefetch stage: program store, fetch PC and a 2-entry
// prefetch queue presenting one {opcode, argA, argB} word at a time to the FSM.
module instr_fetch #(
   parameter int unsigned OP_SIZE  = 4,
   parameter int unsigned ARG_SIZE = 3,
   parameter int unsigned ARG_NUM  = 2,
   parameter int unsigned ADDR_W   = 4,
   localparam int unsigned IW      = OP_SIZE + ARG_NUM * ARG_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [IW-1:0]     load_data,
   input  logic              run,
   input  logic              done,
   input  logic              branch,
   input  logic [ADDR_W-1:0] branchaddress,
   output logic [IW-1:0]     instruction,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     mem [DEPTH];
   logic [IW-1:0]     rd_data;
   logic [ADDR_W-1:0] fetch_pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_addr;
   logic [IW-1:0]     head_word, tail_word;
   logic [ADDR_W-1:0] head_addr, tail_addr;
   logic [1:0]        occ;
   logic              pop_c;
   logic              issue_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state, pop and issue decisions; slots available = occ + inflight - pop < 2
   always_comb begin
      state_d = state_q;
      pop_c   = 1'b0;
      issue_c = 1'b0;
      case (state_q)
         IDLE:    if (run)  state_d = FETCH;
         FETCH:   if (!run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      pop_c   = done && (occ != 2'd0) && !branch;
      issue_c = run && !branch &&
                ((3'(occ) + 3'(inflight)) < (3'd2 + 3'(pop_c)));
   end

   // Program store: survives reset, loads only while stopped, 1-cycle read
   always_ff @(posedge clk) begin
      if (load_en && !run) mem[load_addr] <= load_data;
      if (issue_c)         rd_data <= mem[fetch_pc];
   end

   // Fetch pointer, inflight tracking and queue; unused slots are kept zero
   always_ff @(posedge clk) begin
      if (rst || branch) begin
         fetch_pc      <= rst ? '0 : branchaddress;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         occ           <= 2'd0;
         head_word     <= '0;
         head_addr     <= '0;
         tail_word     <= '0;
         tail_addr     <= '0;
      end else begin
         inflight <= issue_c;
         if (issue_c) begin
            fetch_pc      <= fetch_pc + ADDR_W'(1);
            inflight_addr <= fetch_pc;
         end
         case ({pop_c, inflight})
            2'b11: begin
               if (occ == 2'd2) begin
                  head_word <= tail_word;
                  head_addr <= tail_addr;
                  tail_word <= rd_data;
                  tail_addr <= inflight_addr;
               end else begin
                  head_word <= rd_data;
                  head_addr <= inflight_addr;
               end
            end
            2'b10: begin
               head_word <= tail_word;
               head_addr <= tail_addr;
               tail_word <= '0;
               tail_addr <= '0;
               occ       <= occ - 2'd1;
            end
            2'b01: begin
               if (occ == 2'd0) begin
                  head_word <= rd_data;
                  head_addr <= inflight_addr;
               end else begin
                  tail_word <= rd_data;
                  tail_addr <= inflight_addr;
               end
               occ <= occ + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign instruction = head_word;
   assign pc          = head_addr;
   assign instr_valid = (occ != 2'd0);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: startup, streaming, branch,
// wrap, done+branch collision, load lockout, reset and run deassert.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_en;
   logic [3:0] load_addr;
   logic [9:0] load_data;
   logic       run;
   logic       done;
   logic       branch;
   logic [3:0] branchaddress;
   logic [9:0] instruction;
   logic       instr_valid;
   logic [3:0] pc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .run(run), .done(done), .branch(branch),
      .branchaddress(branchaddress), .instruction(instruction),
      .instr_valid(instr_valid), .pc(pc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic v, input logic [9:0] ins, input logic [3:0] p);
      check({tag, ".valid"}, 32'(instr_valid), 32'(v));
      check({tag, ".instr"}, 32'(instruction), 32'(ins));
      check({tag, ".pc"},    32'(pc),          32'(p));
   endtask

   task automatic load(input logic [3:0] a, input logic [9:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      step();
      load_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      run = 1'b0; done = 1'b0; branch = 1'b0; branchaddress = '0;
      step(); step();
      check_head("reset", 1'b0, 10'h000, 4'd0);
      rst = 1'b0;

      load(4'd0, 10'h101); load(4'd1, 10'h0A3); load(4'd2, 10'h2C5);
      load(4'd3, 10'h3FF); load(4'd15, 10'h1E7);
      rst = 1'b1; step(); rst = 1'b0;

      // Startup then fill-and-stall with no done
      run = 1'b1;
      step();
      check_head("startup_n", 1'b0, 10'h000, 4'd0);
      step();
      check_head("startup_n1", 1'b1, 10'h101, 4'd0);
      step(); step(); step();
      check_head("full_hold", 1'b1, 10'h101, 4'd0);

      // Streaming with done every cycle from first valid
      rst = 1'b1; step(); rst = 1'b0;
      step(); step();
      check_head("stream0", 1'b1, 10'h101, 4'd0);
      done = 1'b1;
      step(); check_head("stream1", 1'b1, 10'h0A3, 4'd1);
      step(); check_head("stream2", 1'b1, 10'h2C5, 4'd2);
      step(); check_head("stream3", 1'b1, 10'h3FF, 4'd3);
      done = 1'b0;

      // Branch to 2 while addr1 (0x0A3) is inflight
      rst = 1'b1; step(); rst = 1'b0;
      step(); step();
      branch = 1'b1; branchaddress = 4'd2;
      step(); branch = 1'b0;
      check_head("br_flush", 1'b0, 10'h000, 4'd0);
      step(); check_head("br_n1", 1'b0, 10'h000, 4'd0);
      step(); check_head("br_n2", 1'b1, 10'h2C5, 4'd2);
      step(); step(); check_head("br_hold", 1'b1, 10'h2C5, 4'd2);

      // Branch to 15 and pop across the wrap
      branch = 1'b1; branchaddress = 4'd15;
      step(); branch = 1'b0;
      step(); step();
      check_head("wrap15", 1'b1, 10'h1E7, 4'd15);
      done = 1'b1;
      step(); done = 1'b0;
      check_head("wrap0", 1'b1, 10'h101, 4'd0);

      // done and branch together with a full queue: branch wins, no extra pop
      step();
      done = 1'b1; branch = 1'b1; branchaddress = 4'd1;
      step(); done = 1'b0; branch = 1'b0;
      check("db_flush.valid", 32'(instr_valid), 32'd0);
      step(); step();
      check_head("db_target", 1'b1, 10'h0A3, 4'd1);
      step(); check_head("db_nopop", 1'b1, 10'h0A3, 4'd1);

      // Load while running is dropped; reset mid-stream clears the queue
      load(4'd0, 10'h000);
      rst = 1'b1; step(); rst = 1'b0;
      check_head("rst_mid", 1'b0, 10'h000, 4'd0);
      step(); step();
      check_head("load_ignored", 1'b1, 10'h101, 4'd0);

      // run deassert: inflight still lands, queue drains by pops, empty done ignored
      run = 1'b0; done = 1'b1;
      step(); check_head("stop_pop1", 1'b1, 10'h0A3, 4'd1);
      step(); check_head("stop_empty", 1'b0, 10'h000, 4'd0);
      step(); done = 1'b0;
      check_head("empty_done", 1'b0, 10'h000, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
